// File: rtl/a25_wb_resp_pkg.sv
// ---------------------------------------------------------------------------
// a25_wb_resp_pkg
//   Shared types and helpers for the a25_wb_responder Wishbone memory slave:
//   responder FSM state encoding, LFSR seed/tap constants used by the
//   optional random wait-state generator, and small constant functions.
// ---------------------------------------------------------------------------
package a25_wb_resp_pkg;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_WAIT = 2'd1,
    RS_ACK  = 2'd2
  } resp_state_t;

  // 16-bit Fibonacci LFSR, taps 16/14/13/11 -> bits 15/13/12/10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Ceiling log2 for index widths; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/a25_wb_resp_mem.sv
// ---------------------------------------------------------------------------
// a25_wb_resp_mem
//   Single-port synchronous RAM with per-byte write enables, a registered
//   read port (1-cycle latency) and write-first behaviour: on a write the
//   read register captures the merged, newly written word.
//
//   i_clk    clock (rising edge)
//   i_rst    synchronous active-high reset, clears the read register only
//   i_en     access enable for this cycle
//   i_we     1 = write, 0 = read
//   i_sel    byte enables (DWIDTH/8)
//   i_addr   word index
//   i_wdat   write data
//   o_rdat   registered read data
// ---------------------------------------------------------------------------
module a25_wb_resp_mem
  import a25_wb_resp_pkg::*;
#(
  parameter int DWIDTH    = 128,
  parameter int MEM_WORDS = 1024,
  parameter int IW        = clog2(MEM_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [DWIDTH/8-1:0]   i_sel,
  input  logic [IW-1:0]         i_addr,
  input  logic [DWIDTH-1:0]     i_wdat,
  output logic [DWIDTH-1:0]     o_rdat
);

  localparam int SW = DWIDTH / 8;

  logic [DWIDTH-1:0] mem [MEM_WORDS];
  logic [DWIDTH-1:0] merged;

  // Word as it will look after this cycle's write.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    merged = mem[i_addr];
    for (int b = 0; b < SW; b++) begin
      if (i_sel[b]) merged[b*8 +: 8] = i_wdat[b*8 +: 8];
    end
  end

  // NOTE: the storage array has no reset; only control/output registers do.
  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < SW; b++) begin
        if (i_sel[b]) mem[i_addr][b*8 +: 8] <= i_wdat[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdat <= '0;
    end else if (i_en) begin
      o_rdat <= i_we ? merged : mem[i_addr];
    end
  end

endmodule

// File: rtl/a25_wb_responder.sv
// ---------------------------------------------------------------------------
// a25_wb_responder
//   Wishbone slave terminating the a25_wishbone master. Each beat (single or
//   part of a 4-beat burst) is accepted in RS_IDLE, optionally held for W
//   wait states in RS_WAIT, and acknowledged for one cycle in RS_ACK. The
//   memory access happens on the edge entering RS_ACK, so o_wb_dat is valid
//   during the ack cycle.
//
//   Optional feature macro: A25_WB_RESP_RANDWAIT_EN
//     defined   : W = min(WAIT_CYCLES + lfsr[1:0], 255), LFSR free-running
//     undefined : W = WAIT_CYCLES, no LFSR
//
//   i_clk       sole clock, rising edge
//   i_rst       synchronous active-high reset
//   i_wb_adr    byte address (higher bits alias)
//   i_wb_sel    byte enables
//   i_wb_we     1 = write
//   i_wb_cyc    cycle valid
//   i_wb_stb    strobe
//   i_wb_dat    write data
//   o_wb_dat    read data, valid while o_wb_ack = 1
//   o_wb_ack    one-cycle acknowledge
//   o_beat_cnt  acks in the current cycle, modulo 4
//   o_busy      high whenever the FSM is not in RS_IDLE
// ---------------------------------------------------------------------------
module a25_wb_responder
  import a25_wb_resp_pkg::*;
#(
  parameter int DWIDTH      = 128,
  parameter int AWIDTH      = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [AWIDTH-1:0]   i_wb_adr,
  input  logic [DWIDTH/8-1:0] i_wb_sel,
  input  logic                i_wb_we,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  input  logic [DWIDTH-1:0]   i_wb_dat,
  output logic [DWIDTH-1:0]   o_wb_dat,
  output logic                o_wb_ack,
  output logic [1:0]          o_beat_cnt,
  output logic                o_busy
);

  localparam int SW = DWIDTH / 8;
  localparam int BW = clog2(SW);
  localparam int IW = clog2(MEM_WORDS);

  resp_state_t         state;
  logic [7:0]          wait_cnt;
  logic [7:0]          beat_w;
  logic [IW-1:0]       idx_q;
  logic                we_q;
  logic [SW-1:0]       sel_q;
  logic [DWIDTH-1:0]   dat_q;

  logic                req;
  logic                enter_ack;
  logic                live;
  logic                mem_en;
  logic                mem_we;
  logic [SW-1:0]       mem_sel;
  logic [IW-1:0]       mem_idx;
  logic [DWIDTH-1:0]   mem_wdat;

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic                unused_adr;
  assign unused_adr = ^i_wb_adr;

  assign req    = i_wb_cyc & i_wb_stb;
  assign o_busy = (state != RS_IDLE);
  // Ack is simply the RS_ACK state, which always lasts exactly one cycle.
  assign o_wb_ack = (state == RS_ACK);

`ifdef A25_WB_RESP_RANDWAIT_EN
  logic [15:0] lfsr;
  logic [8:0]  w_sum;

  always_ff @(posedge i_clk) begin
    if (i_rst) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  assign w_sum  = 9'(WAIT_CYCLES) + {7'd0, lfsr[1:0]};
  assign beat_w = w_sum[8] ? 8'hFF : w_sum[7:0];
`else
  assign beat_w = 8'(WAIT_CYCLES);
`endif

  // Memory is accessed on the edge that enters RS_ACK. With zero wait
  // states that edge is the acceptance edge, so the live bus is used;
  // otherwise the request latched at acceptance is used.
  always_comb begin
    enter_ack = 1'b0;
    case (state)
      RS_IDLE: enter_ack = req && (beat_w == 8'd0);
      RS_WAIT: enter_ack = i_wb_cyc && (wait_cnt <= 8'd1);
      default: enter_ack = 1'b0;
    endcase
  end

  assign live     = (state == RS_IDLE);
  assign mem_idx  = live ? i_wb_adr[BW +: IW] : idx_q;
  assign mem_we   = live ? i_wb_we            : we_q;
  assign mem_sel  = live ? i_wb_sel           : sel_q;
  assign mem_wdat = live ? i_wb_dat           : dat_q;
  // Reset wins over a beat completing in the same cycle: no write, no read.
  assign mem_en   = enter_ack && !i_rst;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= RS_IDLE;
      wait_cnt   <= 8'd0;
      o_beat_cnt <= 2'd0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
    end else begin
      case (state)
        RS_IDLE: begin
          if (req) begin
            idx_q <= i_wb_adr[BW +: IW];
            we_q  <= i_wb_we;
            sel_q <= i_wb_sel;
            dat_q <= i_wb_dat;
            if (beat_w == 8'd0) begin
              state <= RS_ACK;
            end else begin
              wait_cnt <= beat_w;
              state    <= RS_WAIT;
            end
          end
        end
        RS_WAIT: begin
          // A cyc drop wins even on the edge the count would expire.
          if (!i_wb_cyc) begin
            wait_cnt <= 8'd0;
            state    <= RS_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
            if (wait_cnt <= 8'd1) state <= RS_ACK;
          end
        end
        // Master's stb during the ack cycle still refers to this beat.
        RS_ACK:  state <= RS_IDLE;
        default: state <= RS_IDLE;
      endcase

      if (!i_wb_cyc)      o_beat_cnt <= 2'd0;
      else if (enter_ack) o_beat_cnt <= o_beat_cnt + 2'd1;
    end
  end

  a25_wb_resp_mem #(
    .DWIDTH    (DWIDTH),
    .MEM_WORDS (MEM_WORDS),
    .IW        (IW)
  ) u_mem (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (mem_en),
    .i_we   (mem_we),
    .i_sel  (mem_sel),
    .i_addr (mem_idx),
    .i_wdat (mem_wdat),
    .o_rdat (o_wb_dat)
  );

endmodule

// File: tb/tb_a25_wb_responder.sv
// ---------------------------------------------------------------------------
// tb_a25_wb_responder
//   Directed bench for a25_wb_responder. Four instances with different wait
//   counts (1, 0, 5, 2) share the clock and reset; each has its own master
//   signals. Inputs change on the falling edge, outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_a25_wb_responder;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int ND = 4;
  localparam int WAITS [ND] = '{1, 0, 5, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [AW-1:0]  adr  [ND];
  logic [SW-1:0]  sel  [ND];
  logic           we   [ND];
  logic           cyc  [ND];
  logic           stb  [ND];
  logic [DW-1:0]  wdat [ND];
  logic [DW-1:0]  rdat [ND];
  logic           ack  [ND];
  logic [1:0]     bcnt [ND];
  logic           busy [ND];

  int      checks = 0;
  int      errors = 0;
  int      ack_cnt [ND];
  bit      pend [ND];
  longint  t_last;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    a25_wb_responder #(
      .DWIDTH      (DW),
      .AWIDTH      (AW),
      .MEM_WORDS   (1024),
      .WAIT_CYCLES (WAITS[g])
    ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wb_adr   (adr[g]),
      .i_wb_sel   (sel[g]),
      .i_wb_we    (we[g]),
      .i_wb_cyc   (cyc[g]),
      .i_wb_stb   (stb[g]),
      .i_wb_dat   (wdat[g]),
      .o_wb_dat   (rdat[g]),
      .o_wb_ack   (ack[g]),
      .o_beat_cnt (bcnt[g]),
      .o_busy     (busy[g])
    );
  end

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) if (ack[d] === 1'b1) ack_cnt[d]++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    for (int d = 0; d < ND; d++) pend[d] = 1'b0;
  endtask

  // One beat, called at a falling edge. If the previous beat on this
  // instance just got its ack, the next rising edge only leaves RS_ACK and
  // the request is sampled one edge later. Returns at the ack's falling edge.
  task automatic beat(input int d, input logic [31:0] a, input bit w,
                      input logic [15:0] s, input logic [127:0] dat,
                      input bit keep, output logic [127:0] rd,
                      output int lat, output logic [1:0] bc);
    adr[d] = a; we[d] = w; sel[d] = s; wdat[d] = dat;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    if (pend[d]) @(posedge clk);
    pend[d] = 1'b0;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (ack[d] === 1'b1) begin
        lat = k;
        break;
      end
    end
    rd = rdat[d];
    bc = bcnt[d];
    t_last = $time;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL beat_timeout dut%0d adr=%h: no ack within 300 cycles", d, a);
    end else begin
      pend[d] = 1'b1;
    end
    cyc[d] = keep; stb[d] = keep;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      adr[d] = '0; sel[d] = '0; we[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0;
      wdat[d] = '0; pend[d] = 1'b0; ack_cnt[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      checks++; if (ack[d] !== 1'b0) begin errors++; $display("FAIL reset_ack dut%0d got=%b exp=0", d, ack[d]); end
      checks++; if (rdat[d] !== '0) begin errors++; $display("FAIL reset_dat dut%0d got=%h exp=0", d, rdat[d]); end
      checks++; if (bcnt[d] !== 2'd0) begin errors++; $display("FAIL reset_beat_cnt dut%0d got=%0d exp=0", d, bcnt[d]); end
      checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got=%b exp=0", d, busy[d]); end
    end
  endtask

  task automatic test_write_read;
    logic [127:0] v, rd;
    int lat;
    logic [1:0] bc;
    v = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;
    idle(1);
    beat(0, 32'h1000, 1'b1, 16'hFFFF, v, 1'b0, rd, lat, bc);
    checks++; if (lat != 2) begin errors++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    beat(0, 32'h1000, 1'b0, 16'hFFFF, '0, 1'b0, rd, lat, bc);
    checks++; if (lat != 2) begin errors++; $display("FAIL rd_latency got=%0d exp=2", lat); end
    checks++; if (rd !== v) begin errors++; $display("FAIL rd_after_wr got=%h exp=%h", rd, v); end
  endtask

  task automatic test_byte_enables;
    logic [127:0] rd, exp;
    int lat;
    logic [1:0] bc;
    exp = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0};
    idle(1);
    beat(0, 32'h1010, 1'b1, 16'hFFFF, {128{1'b1}}, 1'b0, rd, lat, bc);
    beat(0, 32'h1010, 1'b1, 16'h000F, '0, 1'b0, rd, lat, bc);
    beat(0, 32'h1010, 1'b0, 16'hFFFF, '0, 1'b0, rd, lat, bc);
    checks++; if (rd !== exp) begin errors++; $display("FAIL byte_enable got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_burst;
    logic [127:0] pat [4];
    logic [127:0] rd;
    longint t_prev;
    int lat, base;
    logic [1:0] bc;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      pat[i] = {4{32'hC0DE_0000 + 32'(i)}};
      beat(1, 32'h2000 + 32'(i * 16), 1'b1, 16'hFFFF, pat[i], 1'b0, rd, lat, bc);
    end
    idle(2);
    base = ack_cnt[1];
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      beat(1, 32'h2000 + 32'(i * 16), 1'b0, 16'hFFFF, '0, (i != 3), rd, lat, bc);
      checks++; if (lat != 1) begin errors++; $display("FAIL burst_latency beat%0d got=%0d exp=1", i, lat); end
      checks++; if (bc !== 2'((i + 1) % 4)) begin errors++; $display("FAIL burst_beat_cnt beat%0d got=%0d exp=%0d", i, bc, (i + 1) % 4); end
      checks++; if (rd !== pat[i]) begin errors++; $display("FAIL burst_data beat%0d got=%h exp=%h", i, rd, pat[i]); end
      if (i > 0) begin
        checks++; if (t_last - t_prev != 20) begin errors++; $display("FAIL burst_spacing beat%0d got=%0d exp=20", i, t_last - t_prev); end
      end
      t_prev = t_last;
    end
    idle(4);
    checks++; if (ack_cnt[1] - base != 4) begin errors++; $display("FAIL burst_ack_count got=%0d exp=4", ack_cnt[1] - base); end
    checks++; if (bcnt[1] !== 2'd0) begin errors++; $display("FAIL burst_cnt_clear got=%0d exp=0", bcnt[1]); end
  endtask

  task automatic test_abort;
    logic [127:0] x, rd;
    int lat, base;
    logic [1:0] bc;
    x = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    idle(1);
    beat(2, 32'h1800, 1'b1, 16'hFFFF, x, 1'b0, rd, lat, bc);
    checks++; if (lat != 6) begin errors++; $display("FAIL abort_pre_latency got=%0d exp=6", lat); end
    idle(1);
    base = ack_cnt[2];
    adr[2] = 32'h1800; we[2] = 1'b1; sel[2] = 16'hFFFF; wdat[2] = ~x;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL abort_busy_wait got=%b exp=1", busy[2]); end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    @(negedge clk);
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL abort_busy_fall got=%b exp=0", busy[2]); end
    idle(10);
    checks++; if (ack_cnt[2] != base) begin errors++; $display("FAIL abort_no_ack got=%0d exp=%0d", ack_cnt[2], base); end
    beat(2, 32'h1800, 1'b0, 16'hFFFF, '0, 1'b0, rd, lat, bc);
    checks++; if (rd !== x) begin errors++; $display("FAIL abort_mem_kept got=%h exp=%h", rd, x); end
  endtask

  task automatic test_reset_mid_wait;
    logic [127:0] x, rd;
    int lat, base;
    logic [1:0] bc;
    x = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
    idle(1);
    beat(2, 32'h1C00, 1'b1, 16'hFFFF, x, 1'b1, rd, lat, bc);
    checks++; if (bc !== 2'd1) begin errors++; $display("FAIL rst_pre_beat_cnt got=%0d exp=1", bc); end
    we[2] = 1'b1; wdat[2] = ~x;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    base = ack_cnt[2];
    checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b exp=1", busy[2]); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ack[2] !== 1'b0) begin errors++; $display("FAIL rst_mid_ack got=%b exp=0", ack[2]); end
    checks++; if (bcnt[2] !== 2'd0) begin errors++; $display("FAIL rst_mid_beat_cnt got=%0d exp=0", bcnt[2]); end
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy[2]); end
    checks++; if (rdat[2] !== '0) begin errors++; $display("FAIL rst_mid_dat got=%h exp=0", rdat[2]); end
    rst = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
    idle(8);
    checks++; if (ack_cnt[2] != base) begin errors++; $display("FAIL rst_no_ack got=%0d exp=%0d", ack_cnt[2], base); end
    beat(2, 32'h1C00, 1'b0, 16'hFFFF, '0, 1'b0, rd, lat, bc);
    checks++; if (rd !== x) begin errors++; $display("FAIL rst_no_write got=%h exp=%h", rd, x); end
  endtask

  task automatic test_random;
    logic [127:0] model [16];
    logic [127:0] dat, rd;
    logic [15:0]  s;
    logic [31:0]  a;
    logic [1:0]   bc;
    int lat, wi, lo, hi;
    bit w, keep;
`ifdef A25_WB_RESP_RANDWAIT_EN
    lo = 3; hi = 6;
`else
    lo = 3; hi = 3;
`endif
    idle(1);
    for (int i = 0; i < 16; i++) begin
      dat = {$urandom, $urandom, $urandom, $urandom};
      beat(3, 32'h3000 | 32'(i << 4), 1'b1, 16'hFFFF, dat, 1'b0, rd, lat, bc);
      model[i] = dat;
    end
    for (int n = 0; n < 1000; n++) begin
      wi   = $urandom_range(0, 15);
      w    = 1'($urandom_range(0, 1));
      s    = 16'($urandom);
      dat  = {$urandom, $urandom, $urandom, $urandom};
      a    = (32'($urandom_range(0, 32'h3FFFF)) << 14) | 32'h3000 |
             32'(wi << 4) | 32'($urandom_range(0, 15));
      keep = (n != 999) && ($urandom_range(0, 1) == 1);
      beat(3, a, w, s, dat, keep, rd, lat, bc);
      checks++;
      if (lat < lo || lat > hi) begin
        errors++; $display("FAIL rand_latency beat%0d got=%0d exp=%0d..%0d", n, lat, lo, hi);
      end
      if (w) begin
        for (int b = 0; b < SW; b++) if (s[b]) model[wi][b*8 +: 8] = dat[b*8 +: 8];
      end else begin
        checks++;
        if (rd !== model[wi]) begin
          errors++; $display("FAIL rand_data beat%0d adr=%h got=%h exp=%h", n, a, rd, model[wi]);
        end
      end
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_burst();
    test_abort();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
